// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin issue scheduler for NUM_WARPS resident warps.
// Tracks each warp through issue, memory wait and retirement; flags done.
module warp_scheduler #(
  parameter int NUM_WARPS = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_BITS = 8,
  parameter logic [PC_BITS-1:0] START_PC = '0,
  localparam int WW = $clog2(NUM_WARPS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WW:0]                 warp_count,
  input  logic                        issue_ready,
  output logic                        issue_valid,
  output logic [WW-1:0]               issue_warp_id,
  output logic [PC_BITS-1:0]          issue_pc,
  output logic [THREADS_PER_WARP-1:0] issue_mask,
  input  logic                        complete_valid,
  input  logic [WW-1:0]               complete_warp_id,
  input  logic [PC_BITS-1:0]          complete_next_pc,
  input  logic [THREADS_PER_WARP-1:0] complete_mask,
  input  logic                        complete_ret,
  input  logic                        complete_mem,
  input  logic                        mem_done_valid,
  input  logic [WW-1:0]               mem_done_warp_id,
  output logic                        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  typedef enum logic [2:0] {
    W_INACTIVE,
    W_READY,
    W_ISSUED,
    W_MEM_WAIT,
    W_RETIRED
  } wst_t;

  fsm_t                        fsm;
  wst_t                        wst     [NUM_WARPS];
  logic [PC_BITS-1:0]          pc_q    [NUM_WARPS];
  logic [THREADS_PER_WARP-1:0] mask_q  [NUM_WARPS];
  logic [WW-1:0]               last_issued;

  logic                        sel_found;
  logic [WW-1:0]               sel_id;
  logic [WW-1:0]               cand;
  logic                        fire;
  logic                        all_retired;
  logic [WW:0]                 launch_n;
  logic [NUM_WARPS-1:0]        issue_hit;
  logic [NUM_WARPS-1:0]        cpl_hit;
  logic [NUM_WARPS-1:0]        mem_hit;
  logic                        cpl_kill;

  // Rotating priority: scan upward from the warp after the last issued one.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      cand = last_issued + WW'(k);
      if (!sel_found && wst[cand] == W_READY) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign issue_valid   = (fsm == S_RUN) && sel_found;
  assign issue_warp_id = issue_valid ? sel_id : '0;
  assign issue_pc      = issue_valid ? pc_q[sel_id] : '0;
  assign issue_mask    = issue_valid ? mask_q[sel_id] : '0;
  assign fire          = issue_valid && issue_ready;

  assign launch_n = (warp_count > (WW+1)'(NUM_WARPS))
                  ? (WW+1)'(NUM_WARPS) : warp_count;

  assign cpl_kill = complete_ret || (complete_mask == '0);

  always_comb begin
    all_retired = 1'b1;
    issue_hit   = '0;
    cpl_hit     = '0;
    mem_hit     = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (wst[i] != W_RETIRED) all_retired = 1'b0;
      issue_hit[i] = fire && (sel_id == WW'(i));
      cpl_hit[i]   = complete_valid
                  && (complete_warp_id == WW'(i))
                  && (wst[i] == W_ISSUED);
      mem_hit[i]   = mem_done_valid
                  && (mem_done_warp_id == WW'(i))
                  && (wst[i] == W_MEM_WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm         <= S_IDLE;
      done        <= 1'b0;
      last_issued <= WW'(NUM_WARPS - 1);
      for (int i = 0; i < NUM_WARPS; i++) begin
        wst[i]    <= W_INACTIVE;
        pc_q[i]   <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (start) begin
            fsm <= S_RUN;
            for (int i = 0; i < NUM_WARPS; i++) begin
              if ((WW+1)'(i) < launch_n) begin
                wst[i]    <= W_READY;
                pc_q[i]   <= START_PC;
                mask_q[i] <= '1;
              end else begin
                wst[i]    <= W_RETIRED;
              end
            end
          end
        end
        S_RUN: begin
          if (all_retired) begin
            fsm  <= S_DONE;
            done <= 1'b1;
          end
          if (fire) last_issued <= sel_id;
          // The three hits need distinct warp states, so they never overlap.
          for (int i = 0; i < NUM_WARPS; i++) begin
            unique case (1'b1)
              issue_hit[i]: wst[i] <= W_ISSUED;
              cpl_hit[i]: begin
                if (cpl_kill) begin
                  wst[i] <= W_RETIRED;
                end else begin
                  pc_q[i]   <= complete_next_pc;
                  mask_q[i] <= complete_mask;
                  wst[i]    <= complete_mem ? W_MEM_WAIT : W_READY;
                end
              end
              mem_hit[i]: wst[i] <= W_READY;
              default: ;
            endcase
          end
        end
        S_DONE: ;
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: directed scenario bench for warp_scheduler.
// Each task drives one scenario and checks hand-computed outputs inline.
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] warp_count;
  logic       issue_ready;
  logic       issue_valid;
  logic [1:0] issue_warp_id;
  logic [7:0] issue_pc;
  logic [3:0] issue_mask;
  logic       complete_valid;
  logic [1:0] complete_warp_id;
  logic [7:0] complete_next_pc;
  logic [3:0] complete_mask;
  logic       complete_ret;
  logic       complete_mem;
  logic       mem_done_valid;
  logic [1:0] mem_done_warp_id;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  warp_scheduler #(
    .NUM_WARPS(4),
    .THREADS_PER_WARP(4),
    .PC_BITS(8),
    .START_PC(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .warp_count(warp_count),
    .issue_ready(issue_ready),
    .issue_valid(issue_valid),
    .issue_warp_id(issue_warp_id),
    .issue_pc(issue_pc),
    .issue_mask(issue_mask),
    .complete_valid(complete_valid),
    .complete_warp_id(complete_warp_id),
    .complete_next_pc(complete_next_pc),
    .complete_mask(complete_mask),
    .complete_ret(complete_ret),
    .complete_mem(complete_mem),
    .mem_done_valid(mem_done_valid),
    .mem_done_warp_id(mem_done_warp_id),
    .done(done)
  );

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    start            = 1'b0;
    warp_count       = 3'd0;
    issue_ready      = 1'b0;
    complete_valid   = 1'b0;
    complete_warp_id = 2'd0;
    complete_next_pc = 8'h00;
    complete_mask    = 4'hf;
    complete_ret     = 1'b0;
    complete_mem     = 1'b0;
    mem_done_valid   = 1'b0;
    mem_done_warp_id = 2'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    cyc();
    cyc();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", issue_valid); end
    n_checks++; if (issue_warp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", issue_warp_id); end
    n_checks++; if (issue_pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", issue_pc); end
    n_checks++; if (issue_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %0h want 0", issue_mask); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b1;
    cyc();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", issue_valid); end
  endtask

  task automatic test_round_robin;
    int prev_id;
    int prev_pc;
    start       = 1'b1;
    warp_count  = 3'd3;
    issue_ready = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++; if (issue_mask !== 4'hf) begin n_fail++; $display("FAIL rr_mask: got %0h want f", issue_mask); end
    prev_id = 0;
    prev_pc = 0;
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", i, issue_valid); end
      n_checks++; if (issue_warp_id !== 2'(i % 3)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, issue_warp_id, i % 3); end
      n_checks++; if (issue_pc !== 8'(i / 3)) begin n_fail++; $display("FAIL rr_pc[%0d]: got %0d want %0d", i, issue_pc, i / 3); end
      complete_valid   = (i > 0);
      complete_warp_id = 2'(prev_id);
      complete_next_pc = 8'(prev_pc + 1);
      complete_mask    = 4'hf;
      prev_id = i % 3;
      prev_pc = i / 3;
      cyc();
    end
    issue_ready      = 1'b0;
    complete_valid   = 1'b1;
    complete_warp_id = 2'd2;
    complete_next_pc = 8'd3;
    cyc();
    complete_valid = 1'b0;
    n_checks++; if (issue_warp_id !== 2'd0 || issue_pc !== 8'd3) begin n_fail++; $display("FAIL rr_tail: got id %0d pc %0d want id 0 pc 3", issue_warp_id, issue_pc); end
  endtask

  task automatic test_mem_wait;
    int ids [9];
    int pcs [9];
    ids = '{0, 1, 2, 0, 2, 0, 2, 0, 1};
    pcs = '{3, 3, 3, 4, 4, 5, 5, 6, 4};
    issue_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL mem_valid[%0d]: got %b want 1", i, issue_valid); end
      n_checks++; if (issue_warp_id !== 2'(ids[i])) begin n_fail++; $display("FAIL mem_id[%0d]: got %0d want %0d", i, issue_warp_id, ids[i]); end
      n_checks++; if (issue_pc !== 8'(pcs[i])) begin n_fail++; $display("FAIL mem_pc[%0d]: got %0d want %0d", i, issue_pc, pcs[i]); end
      complete_valid   = (i > 0);
      complete_warp_id = (i > 0) ? 2'(ids[(i > 0) ? i - 1 : 0]) : 2'd0;
      complete_next_pc = (i > 0) ? 8'(pcs[(i > 0) ? i - 1 : 0] + 1) : 8'd0;
      complete_mem     = (i == 2);
      mem_done_valid   = (i == 6);
      mem_done_warp_id = 2'd1;
      cyc();
    end
    issue_ready      = 1'b0;
    complete_valid   = 1'b1;
    complete_warp_id = 2'd1;
    complete_next_pc = 8'd5;
    complete_mem     = 1'b0;
    mem_done_valid   = 1'b0;
    cyc();
    complete_valid = 1'b0;
    n_checks++; if (issue_warp_id !== 2'd2 || issue_pc !== 8'd6) begin n_fail++; $display("FAIL mem_tail: got id %0d pc %0d want id 2 pc 6", issue_warp_id, issue_pc); end
  endtask

  task automatic test_stall;
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, issue_valid); end
      n_checks++; if (issue_warp_id !== 2'd2) begin n_fail++; $display("FAIL stall_id[%0d]: got %0d want 2", i, issue_warp_id); end
      n_checks++; if (issue_pc !== 8'd6) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0d want 6", i, issue_pc); end
      cyc();
    end
  endtask

  task automatic test_stray;
    complete_valid   = 1'b1;
    complete_warp_id = 2'd0;
    complete_next_pc = 8'h55;
    complete_mask    = 4'h0;
    complete_ret     = 1'b1;
    cyc();
    complete_valid = 1'b0;
    complete_ret   = 1'b0;
    complete_mask  = 4'hf;
    n_checks++; if (issue_warp_id !== 2'd2 || issue_pc !== 8'd6) begin n_fail++; $display("FAIL stray_cpl_hold: got id %0d pc %0d want id 2 pc 6", issue_warp_id, issue_pc); end
    issue_ready = 1'b1;
    cyc();
    issue_ready = 1'b0;
    n_checks++; if (issue_warp_id !== 2'd0 || issue_pc !== 8'd7) begin n_fail++; $display("FAIL stray_cpl: got id %0d pc %0d want id 0 pc 7", issue_warp_id, issue_pc); end
    n_checks++; if (issue_mask !== 4'hf) begin n_fail++; $display("FAIL stray_mask: got %0h want f", issue_mask); end
    mem_done_valid   = 1'b1;
    mem_done_warp_id = 2'd2;
    cyc();
    mem_done_valid = 1'b0;
    n_checks++; if (issue_warp_id !== 2'd0 || issue_pc !== 8'd7) begin n_fail++; $display("FAIL stray_mem_hold: got id %0d pc %0d want id 0 pc 7", issue_warp_id, issue_pc); end
    issue_ready = 1'b1;
    cyc();
    n_checks++; if (issue_warp_id !== 2'd1 || issue_pc !== 8'd5) begin n_fail++; $display("FAIL stray_next: got id %0d pc %0d want id 1 pc 5", issue_warp_id, issue_pc); end
    cyc();
    issue_ready = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL stray_mem: got valid %b want 0", issue_valid); end
  endtask

  task automatic test_retire;
    complete_valid   = 1'b1;
    complete_warp_id = 2'd0;
    complete_next_pc = 8'd0;
    complete_mask    = 4'h0;
    cyc();
    complete_warp_id = 2'd1;
    complete_mask    = 4'hf;
    complete_ret     = 1'b1;
    cyc();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL retire_early: got done %b want 0", done); end
    complete_warp_id = 2'd2;
    cyc();
    idle_inputs();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL retire_e1: got done %b want 0", done); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL retire_valid: got %b want 0", issue_valid); end
    cyc();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL retire_e2: got done %b want 1", done); end
    start      = 1'b1;
    warp_count = 3'd3;
    cyc();
    cyc();
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL done_hold: got done %b valid %b want 1 0", done, issue_valid); end
  endtask

  task automatic test_zero_count;
    do_reset();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_reset: got done %b want 0", done); end
    start       = 1'b1;
    warp_count  = 3'd0;
    issue_ready = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++; if (issue_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_t1: got valid %b done %b want 0 0", issue_valid, done); end
    cyc();
    n_checks++; if (issue_valid !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL zero_t2: got valid %b done %b want 0 1", issue_valid, done); end
    issue_ready = 1'b0;
  endtask

  task automatic test_clamp;
    do_reset();
    start       = 1'b1;
    warp_count  = 3'd7;
    issue_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'(i)) begin n_fail++; $display("FAIL clamp[%0d]: got valid %b id %0d want 1 %0d", i, issue_valid, issue_warp_id, i); end
      cyc();
    end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_end: got valid %b want 0", issue_valid); end
    issue_ready = 1'b0;
  endtask

  task automatic test_reset_midrun;
    do_reset();
    start       = 1'b1;
    warp_count  = 3'd3;
    issue_ready = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++; if (issue_warp_id !== 2'd0) begin n_fail++; $display("FAIL mid_first: got id %0d want 0", issue_warp_id); end
    cyc();
    complete_valid   = 1'b1;
    complete_warp_id = 2'd0;
    complete_next_pc = 8'd9;
    complete_mem     = 1'b1;
    cyc();
    complete_warp_id = 2'd1;
    issue_ready      = 1'b0;
    cyc();
    idle_inputs();
    n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'd2 || issue_mask !== 4'hf) begin n_fail++; $display("FAIL mid_offer: got valid %b id %0d mask %0h want 1 2 f", issue_valid, issue_warp_id, issue_mask); end
    reset = 1'b0;
    cyc();
    n_checks++; if (issue_valid !== 1'b0 || issue_warp_id !== 2'd0) begin n_fail++; $display("FAIL mid_rst_vid: got valid %b id %0d want 0 0", issue_valid, issue_warp_id); end
    n_checks++; if (issue_pc !== 8'd0 || issue_mask !== 4'h0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got pc %0d mask %0h done %b want 0 0 0", issue_pc, issue_mask, done); end
    reset = 1'b1;
    cyc();
    start      = 1'b1;
    warp_count = 3'd2;
    cyc();
    start = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || issue_warp_id !== 2'd0) begin n_fail++; $display("FAIL restart_id: got valid %b id %0d want 1 0", issue_valid, issue_warp_id); end
    n_checks++; if (issue_pc !== 8'd0 || issue_mask !== 4'hf) begin n_fail++; $display("FAIL restart_pc: got pc %0d mask %0h want 0 f", issue_pc, issue_mask); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_mem_wait();
    test_stall();
    test_stray();
    test_retire();
    test_zero_count();
    test_clamp();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Multi-warp issue scheduler for the next-generation compute core. It is the successor of the single-block core scheduler: one core holds up to NUM_WARPS resident warps, each with its own PC and active-thread mask. Each cycle it picks one ready warp round-robin and presents it to the shared fetch/decode/execute pipeline. It tracks each warp through issue, memory wait and retirement, and raises `done` once every launched warp has executed RET or lost all active threads.

## Interface
Parameters:
- NUM_WARPS, 4, resident warps per core (power of two, ≥2)
- THREADS_PER_WARP, 4, width of each warp's thread mask
- PC_BITS, 8, program counter width
- START_PC, 0, PC loaded into every launched warp

Ports:
- clk  in  1  core clock; single clock domain
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk)
- start  in  1  launch request; sampled only in IDLE
- warp_count  in  $clog2(NUM_WARPS)+1  number of warps to launch (0..NUM_WARPS)
- issue_ready  in  1  pipeline accepts an instruction this cycle
- issue_valid  out  1  a warp is being offered
- issue_warp_id  out  $clog2(NUM_WARPS)  offered warp
- issue_pc  out  PC_BITS  PC of offered warp
- issue_mask  out  THREADS_PER_WARP  active mask of offered warp
- complete_valid  in  1  pipeline reports an issued instruction finished
- complete_warp_id  in  $clog2(NUM_WARPS)  warp being completed
- complete_next_pc  in  PC_BITS  warp's new PC
- complete_mask  in  THREADS_PER_WARP  warp's new active mask (post-branch/SYNC)
- complete_ret  in  1  instruction was RET
- complete_mem  in  1  instruction left loads/stores outstanding
- mem_done_valid  in  1  memory ops of a warp have all returned
- mem_done_warp_id  in  $clog2(NUM_WARPS)  warp whose memory ops returned
- done  out  1  all launched warps retired

## Operation
- Top FSM: IDLE → RUN → DONE. DONE is held until reset; a new `start` is ignored in RUN and DONE.
- IDLE with start=1:
  - Warps 0..warp_count-1 go to READY with pc=START_PC and mask all-ones.
  - Remaining warps go to RETIRED.
  - FSM goes to RUN.
- warp_count=0 or warp_count>NUM_WARPS:
  - 0 gives RUN with nothing READY; the all-retired check fires, so done=1 two cycles after start.
  - Values above NUM_WARPS are clamped to NUM_WARPS.
- Per-warp state: INACTIVE, READY, ISSUED, MEM_WAIT, RETIRED.
  - Reset puts every warp in INACTIVE.
  - start moves inactive warps to RETIRED as above.
- Issue selection:
  - Search READY warps starting at (last_issued+1) mod NUM_WARPS, ascending with wrap.
  - The first hit drives issue_*; issue_valid=0 when none is READY or the FSM is not RUN.
  - On issue_valid && issue_ready, that warp goes to ISSUED and last_issued is updated.
  - last_issued resets to NUM_WARPS-1, so warp 0 wins first.
- Completion (complete_valid, target warp in ISSUED), first match wins:
  - complete_ret=1 or complete_mask==0 → RETIRED.
  - Otherwise pc←complete_next_pc and mask←complete_mask; then MEM_WAIT if complete_mem=1, else READY.
- mem_done_valid with target warp in MEM_WAIT → READY.
- Events aimed at a warp in any other state are ignored; they change no state.
- Simultaneous events on different warps in one cycle (issue, completion, mem_done) all take effect.
- A warp made READY in cycle N is not eligible for issue until cycle N+1.
- Multiple warps may be ISSUED at once; the scheduler imposes no limit.
- RUN → DONE when every warp is RETIRED.

## Timing
- Outputs during and after reset: issue_valid=0, issue_warp_id=0, issue_pc=0, issue_mask=0, done=0.
- issue_* are combinational from registered state.
  - issue_ready does not feed back into issue_* within the same cycle.
  - issue_* stay stable while issue_valid=1 && issue_ready=0.
- start sampled at edge T → issue_valid=1 with warp 0, pc=START_PC, in cycle T+1.
- Issue handshake at edge E → the warp is absent from selection from cycle E+1.
- Completion or mem_done at edge E → warp READY (or RETIRED) in cycle E+1; it may issue at edge E+1.
- Last warp retires at edge E → all-retired seen in cycle E+1 → done=1 from cycle E+2. done is registered.
- Reset asserted mid-RUN → on the next edge all warps go INACTIVE, the FSM goes to IDLE, and all outputs return to reset values.

## Test plan
- Reset then start, warp_count=3, issue_ready=1, each issue completed next cycle with next_pc=pc+1 → issue order 0,1,2,0,1,2…; warp 3 never offered.
- Warp 1 completes with complete_mem=1 → it is skipped in rotation (0,2,0,2…) until mem_done_valid for warp 1, then rejoins on the following cycle.
- issue_ready=0 for 5 cycles → issue_valid, issue_warp_id and issue_pc held constant; no state change.
- Completion with complete_mask=0 for warp 0 and complete_ret=1 for warps 1 and 2 → done=1 exactly two cycles after the last retirement, held until reset.
- Stray events: complete_valid for a READY warp and mem_done for an ISSUED warp → ignored. warp_count=0 → done two cycles after start with issue_valid never set.
- Reset pulsed mid-RUN with 2 warps in MEM_WAIT → all outputs return to 0. A new start with warp_count=2 then issues warp 0 at pc=START_PC.
